mem_stage: RTL
==============

# mem_stage

Memory-access pipeline stage that sits between EX and WB. Takes the EX/MEM flow, runs loads and stores on the data-memory bus with a req/ack handshake, aligns and extends load data, and registers the result into the MEM/WB flow that WB consumes. Stalls the upstream pipeline while an access is outstanding and reports misaligned accesses and bus timeouts.

## Interface
- ACK_TIMEOUT, default 16: maximum cycles a request may wait for dmem_ack before it is abandoned; ≥1.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inflow  in  ex_mem_flow_t  EX/MEM flow. Fields used: valid, alu_result[31:0] (address or ALU value), rs2_data[31:0] (store data), funct3[2:0], mem_ctrl.MemRead, mem_ctrl.MemWrite, pc_write[31:0], immediate[31:0], rd_addr[4:0], wb_ctrl.
- outflow  out  mem_wb_flow_t  registered MEM/WB flow: alu_result, data_in, pc_write, immediate, rd_addr, wb_ctrl.
- stall  out  1  high: upstream stages must hold; inflow must stay stable.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  word-aligned address ({alu_result[31:2], 2'b00}).
- dmem_wdata  out  32  store data replicated into byte lanes.
- dmem_wstrb  out  4  byte enables; 0 for loads.
- dmem_ack  in  1  access complete; dmem_rdata valid the same cycle.
- dmem_rdata  in  32  load word.
- misalign  out  1  one-cycle pulse: misaligned access rejected.
- bus_err  out  1  one-cycle pulse: ACK_TIMEOUT expired.

## Operation
- mem_op = inflow.valid & (MemRead | MemWrite). Non-mem instructions pass through in one cycle, no stall.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0. A misaligned mem_op issues no request, pulses misalign, and writes a bubble (wb_ctrl.RegWrite=0) into outflow.
- States: IDLE, WAIT.
  - IDLE: aligned mem_op drives dmem_req=1. If dmem_ack same cycle: complete, stay IDLE. Else go WAIT, counter=1.
  - WAIT: hold dmem_req and all dmem_* stable. On ack: complete, go IDLE. Else, if counter==ACK_TIMEOUT: drop req, pulse bus_err, write bubble, go IDLE; else counter+1.
- stall = mem_op & aligned & ~dmem_ack & ~timeout_now. Stall falls in the completing cycle so upstream advances at the same edge that latches outflow.
- While stall=1, outflow receives a bubble each edge (RegWrite=0, MemtoReg unchanged irrelevant).
- Store lanes: SB (funct3 000) wdata={4{b}}, wstrb=0001<<addr[1:0]; SH (001) wdata={2{h}}, wstrb=0011<<addr[1:0]; SW (010) wstrb=1111.
- Load extraction from dmem_rdata shifted right by 8*addr[1:0]: LB 000 sign-ext byte, LH 001 sign-ext half, LW 010 word, LBU 100 zero-ext byte, LHU 101 zero-ext half. Other funct3: data_in=0.
- Completed access / pass-through: outflow copies alu_result, pc_write, immediate, rd_addr, wb_ctrl; data_in = extracted load data (0 for non-loads).

## Timing
- Reset (rst_n=0, async): state=IDLE, counter=0, outflow all-zero (RegWrite=0), dmem_req=0, dmem_we=0, dmem_wstrb=0, stall=0, misalign=0, bus_err=0.
- Zero-wait memory (ack in request cycle): 1-cycle MEM, no stall.
- N-cycle ack: stall high for N cycles after the request cycle... precisely, stall high in every request cycle lacking ack; outflow valid the edge after ack.
- Timeout: req held for ACK_TIMEOUT+1 cycles max (IDLE cycle + ACK_TIMEOUT WAIT cycles), then dropped.
- Ack arriving while dmem_req=0 is ignored.
- Reset mid-WAIT: request dropped immediately, no bus_err.
- misalign and bus_err are combinational pulses, one cycle wide, never simultaneous.

## Test plan
- Pass-through ADD, alu_result=0x1234, RegWrite=1 -> next edge outflow.alu_result=0x1234, RegWrite=1, stall never high.
- LB addr 0x1003, rdata=0x80FF_0000 with same-cycle ack -> data_in=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr 0x2002, rs2=0xABCD1234 -> wdata=0x1234_1234, wstrb=1100, we=1.
- LW addr 0x3000, ack after 3 cycles -> stall high 3 cycles, outflow holds bubbles, then data_in=rdata, RegWrite=1.
- LW addr 0x3002 -> no dmem_req, misalign pulse, outflow RegWrite=0.
- ACK_TIMEOUT=4, never ack -> req high 5 cycles, bus_err pulse in 5th, stall drops, bubble written; rst_n=0 mid-WAIT -> req=0 immediately.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Flow payload types shared by the EX/MEM and MEM/WB pipeline boundaries.
package mem_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    // Memory-stage control bits carried from decode
    typedef struct packed {
        logic MemRead;
        logic MemWrite;
    } mem_ctrl_t;

    // Write-back control bits carried from decode
    typedef struct packed {
        logic RegWrite;
        logic MemtoReg;
    } wb_ctrl_t;

    // EX/MEM flow presented to the memory stage
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   rs2_data;
        logic [2:0]        funct3;
        mem_ctrl_t         mem_ctrl;
        logic [XLEN-1:0]   pc_write;
        logic [XLEN-1:0]   immediate;
        logic [REG_AW-1:0] rd_addr;
        wb_ctrl_t          wb_ctrl;
    } ex_mem_flow_t;

    // MEM/WB flow consumed by write-back
    typedef struct packed {
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   data_in;
        logic [XLEN-1:0]   pc_write;
        logic [XLEN-1:0]   immediate;
        logic [REG_AW-1:0] rd_addr;
        wb_ctrl_t          wb_ctrl;
    } mem_wb_flow_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack data bus,
// aligns load data, stalls upstream while an access is outstanding and
// abandons requests that are not acknowledged within ACK_TIMEOUT cycles.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  ex_mem_flow_t inflow,
    output mem_wb_flow_t outflow,
    output logic         stall,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [31:0]  dmem_addr,
    output logic [31:0]  dmem_wdata,
    output logic [3:0]   dmem_wstrb,
    input  logic         dmem_ack,
    input  logic [31:0]  dmem_rdata,
    output logic         misalign,
    output logic         bus_err
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    mem_wb_flow_t       outflow_q, outflow_d;

    logic               mem_op_c;
    logic               aligned_c;
    logic [1:0]         offset_c;
    logic               req_c;
    logic               ack_c;
    logic               timeout_c;
    logic               stall_int_c;
    logic               misalign_int_c;
    logic               pass_c;
    logic [31:0]        shifted_c;
    logic [31:0]        load_data_c;
    logic [31:0]        wdata_c;
    logic [3:0]         wstrb_c;

    // Access decode: operation, byte offset and size-based alignment
    always_comb begin
        offset_c = inflow.alu_result[1:0];
        mem_op_c = inflow.valid & (inflow.mem_ctrl.MemRead | inflow.mem_ctrl.MemWrite);
        case (inflow.funct3[1:0])
            2'b00:   aligned_c = 1'b1;
            2'b01:   aligned_c = ~offset_c[0];
            default: aligned_c = (offset_c == 2'b00);
        endcase
    end

    // Load alignment and sign/zero extension of the returned word
    always_comb begin
        shifted_c = dmem_rdata >> {offset_c, 3'b000};
        case (inflow.funct3)
            3'b000:  load_data_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  load_data_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b010:  load_data_c = shifted_c;
            3'b100:  load_data_c = {24'h000000, shifted_c[7:0]};
            3'b101:  load_data_c = {16'h0000, shifted_c[15:0]};
            default: load_data_c = 32'h0000_0000;
        endcase
    end

    // Store lane replication and byte enables
    always_comb begin
        case (inflow.funct3)
            3'b000: begin
                wdata_c = {4{inflow.rs2_data[7:0]}};
                wstrb_c = 4'b0001 << offset_c;
            end
            3'b001: begin
                wdata_c = {2{inflow.rs2_data[15:0]}};
                wstrb_c = 4'b0011 << offset_c;
            end
            3'b010: begin
                wdata_c = inflow.rs2_data;
                wstrb_c = 4'b1111;
            end
            default: begin
                wdata_c = inflow.rs2_data;
                wstrb_c = 4'b0000;
            end
        endcase
    end

    // Next-state, handshake qualifiers and MEM/WB payload
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        outflow_d      = '0;
        req_c          = mem_op_c & aligned_c;
        ack_c          = req_c & dmem_ack;
        timeout_c      = req_c & ~dmem_ack & (state_q == S_WAIT)
                         & (cnt_q == CNT_W'(ACK_TIMEOUT));
        stall_int_c    = req_c & ~dmem_ack & ~timeout_c;
        misalign_int_c = mem_op_c & ~aligned_c;
        pass_c         = inflow.valid & ~mem_op_c;

        case (state_q)
            S_IDLE: begin
                if (req_c && !dmem_ack) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (!req_c || dmem_ack || timeout_c) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Only pass-through and acknowledged accesses write a real entry
        if (pass_c || ack_c) begin
            outflow_d.alu_result = inflow.alu_result;
            outflow_d.pc_write   = inflow.pc_write;
            outflow_d.immediate  = inflow.immediate;
            outflow_d.rd_addr    = inflow.rd_addr;
            outflow_d.wb_ctrl    = inflow.wb_ctrl;
            outflow_d.data_in    = (ack_c && inflow.mem_ctrl.MemRead) ? load_data_c : 32'h0000_0000;
        end
    end

    // State, wait counter and MEM/WB register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            outflow_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            outflow_q <= outflow_d;
        end
    end

    // Bus and pipeline control; reset drops the request without waiting for a clock
    assign dmem_req   = req_c & rst_n;
    assign dmem_we    = dmem_req & inflow.mem_ctrl.MemWrite;
    assign dmem_addr  = {inflow.alu_result[31:2], 2'b00};
    assign dmem_wdata = wdata_c;
    assign dmem_wstrb = dmem_we ? wstrb_c : 4'b0000;
    assign stall      = stall_int_c & rst_n;
    assign misalign   = misalign_int_c & rst_n;
    assign bus_err    = timeout_c & rst_n;
    assign outflow    = outflow_q;

endmodule
